ysyx22041405_lsu_hs: RTL and testbench

YSYX22041405_LSU_HS -- requirements
Module: ysyx22041405_lsu_hs

---
 rtl/ysyx22041405_lsu_hs.sv | 220 ++++++++++++++++++++++
 tb/tb_ysyx22041405_lsu_hs.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx22041405_lsu_hs.sv
// ---------------------------------------------------------------------------
// ysyx22041405_lsu_hs -- load/store unit with valid/ready handshakes.
//
// Accepts one instruction at a time from EX, issues at most one memory
// request for it, and hands the write-back result to WBU.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   in_*                EX -> LSU instruction (valid/ready)
//   mem_req_*           LSU -> memory request (valid/ready), lane-aligned
//   mem_rsp_*           memory -> LSU read response (valid only)
//   out_*               LSU -> WBU result (valid/ready), misalign flag
//
// Parameters
//   WIDTH               data width, 32 or 64
//   AW                  address width
// ---------------------------------------------------------------------------
module ysyx22041405_lsu_hs #(
  parameter int WIDTH = 32,
  parameter int AW    = 32
) (
  input  logic               clk,
  input  logic               rst,
  // EX -> LSU
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4:0]         in_op,
  input  logic [AW-1:0]      in_addr,
  input  logic [WIDTH-1:0]   in_wdata,
  input  logic [WIDTH-1:0]   in_alu,
  input  logic [4:0]         in_rd,
  input  logic               in_rf_we,
  // memory request
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic               mem_req_we,
  output logic [AW-1:0]      mem_req_addr,
  output logic [WIDTH-1:0]   mem_req_wdata,
  output logic [WIDTH/8-1:0] mem_req_wstrb,
  // memory response
  input  logic               mem_rsp_valid,
  input  logic [WIDTH-1:0]   mem_rsp_rdata,
  // LSU -> WBU
  output logic               out_valid,
  input  logic               out_ready,
  output logic [4:0]         out_rd,
  output logic [WIDTH-1:0]   out_wdata,
  output logic               out_rf_we,
  output logic               out_misalign
);

  localparam int NB = WIDTH / 8;
  localparam int OW = $clog2(NB);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  // ---------------- state ----------------
  logic [1:0]       state_q, state_d;
  logic             req_we_q, req_we_d;
  logic [AW-1:0]    req_addr_q, req_addr_d;
  logic [WIDTH-1:0] req_wdata_q, req_wdata_d;
  logic [NB-1:0]    req_wstrb_q, req_wstrb_d;
  logic [1:0]       size_q, size_d;
  logic             uns_q, uns_d;
  logic [OW-1:0]    off_q, off_d;
  logic [4:0]       rd_q, rd_d;
  logic [WIDTH-1:0] wb_data_q, wb_data_d;
  logic             rf_we_q, rf_we_d;
  logic             mis_q, mis_d;

  // ---------------- input decode ----------------
  logic          is_load, is_store, is_mem, misalign;
  logic [1:0]    size;
  logic [OW-1:0] off;
  logic [15:0]   strb_mask;

  // Both is_load and is_store high is a load.
  assign is_load  = in_op[4];
  assign is_store = in_op[3] & ~in_op[4];
  assign is_mem   = in_op[4] | in_op[3];
  assign size     = in_op[1:0];
  assign off      = in_addr[OW-1:0];

  // Contiguous run of (1 << size) byte enables, before lane shifting.
  assign strb_mask = (16'd1 << (5'd1 << size)) - 16'd1;

  always_comb begin
    case (size)
      2'd0:    misalign = 1'b0;
      2'd1:    misalign = in_addr[0];
      2'd2:    misalign = |in_addr[1:0];
      default: misalign = |in_addr[2:0];
    endcase
  end

  // ---------------- load data extraction ----------------
  logic [WIDTH-1:0] rsp_sh, load_ext;

  assign rsp_sh = mem_rsp_rdata >> {off_q, 3'b000};

  always_comb begin
    load_ext = rsp_sh;
    case (size_q)
      2'd0: load_ext = uns_q ? WIDTH'(rsp_sh[7:0])  : WIDTH'($signed(rsp_sh[7:0]));
      2'd1: load_ext = uns_q ? WIDTH'(rsp_sh[15:0]) : WIDTH'($signed(rsp_sh[15:0]));
      2'd2: load_ext = uns_q ? WIDTH'(rsp_sh[31:0]) : WIDTH'($signed(rsp_sh[31:0]));
      default: load_ext = rsp_sh;
    endcase
  end

  // ---------------- next state ----------------
  always_comb begin
    state_d     = state_q;
    req_we_d    = req_we_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_wstrb_d = req_wstrb_q;
    size_d      = size_q;
    uns_d       = uns_q;
    off_d       = off_q;
    rd_d        = rd_q;
    wb_data_d   = wb_data_q;
    rf_we_d     = rf_we_q;
    mis_d       = mis_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          // Capture everything on accept; outputs only ever read these regs.
          req_we_d    = is_store;
          req_addr_d  = {in_addr[AW-1:OW], {OW{1'b0}}};
          req_wdata_d = in_wdata << {off, 3'b000};
          req_wstrb_d = NB'(strb_mask << off);
          size_d      = size;
          uns_d       = in_op[2];
          off_d       = off;
          rd_d        = in_rd;
          if (is_mem && !misalign) begin
            state_d   = S_REQ;
            rf_we_d   = is_load & in_rf_we;
            mis_d     = 1'b0;
            wb_data_d = '0;
          end else if (is_mem) begin
            // Misaligned: skip memory, report straight back.
            state_d   = S_RESP;
            rf_we_d   = 1'b0;
            mis_d     = 1'b1;
            wb_data_d = '0;
          end else begin
            state_d   = S_RESP;
            rf_we_d   = in_rf_we;
            mis_d     = 1'b0;
            wb_data_d = in_alu;
          end
        end
      end
      S_REQ: begin
        if (mem_req_ready) state_d = req_we_q ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        if (mem_rsp_valid) begin
          wb_data_d = load_ext;
          state_d   = S_RESP;
        end
      end
      S_RESP: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_wstrb_q <= '0;
      size_q      <= 2'd0;
      uns_q       <= 1'b0;
      off_q       <= '0;
      rd_q        <= 5'd0;
      wb_data_q   <= '0;
      rf_we_q     <= 1'b0;
      mis_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_we_q    <= req_we_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_wstrb_q <= req_wstrb_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      off_q       <= off_d;
      rd_q        <= rd_d;
      wb_data_q   <= wb_data_d;
      rf_we_q     <= rf_we_d;
      mis_q       <= mis_d;
    end
  end

  // ---------------- outputs ----------------
  assign in_ready      = (state_q == S_IDLE);
  assign mem_req_valid = (state_q == S_REQ);
  assign mem_req_we    = req_we_q;
  assign mem_req_addr  = req_addr_q;
  assign mem_req_wdata = req_wdata_q;
  assign mem_req_wstrb = req_wstrb_q;
  assign out_valid     = (state_q == S_RESP);
  assign out_rd        = rd_q;
  assign out_wdata     = wb_data_q;
  assign out_rf_we     = rf_we_q;
  assign out_misalign  = mis_q;

endmodule

// File: tb/tb_ysyx22041405_lsu_hs.sv
// Bench for ysyx22041405_lsu_hs: one 32-bit and one 64-bit instance share
// the stimulus; sel64 picks which one is offered instructions and observed.
module tb_ysyx22041405_lsu_hs;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        sel64;
  logic        in_valid;
  logic [4:0]  in_op;
  logic [31:0] in_addr;
  logic [63:0] in_wdata, in_alu;
  logic [4:0]  in_rd;
  logic        in_rf_we;
  logic        mem_req_ready, mem_rsp_valid, out_ready;
  logic [63:0] mem_rsp_rdata;

  // 32-bit instance outputs
  logic        a_in_ready, a_req_valid, a_req_we, a_out_valid, a_rf_we, a_mis;
  logic [31:0] a_req_addr, a_req_wdata, a_out_wdata;
  logic [3:0]  a_wstrb;
  logic [4:0]  a_rd;
  // 64-bit instance outputs
  logic        b_in_ready, b_req_valid, b_req_we, b_out_valid, b_rf_we, b_mis;
  logic [31:0] b_req_addr;
  logic [63:0] b_req_wdata, b_out_wdata;
  logic [7:0]  b_wstrb;
  logic [4:0]  b_rd;

  ysyx22041405_lsu_hs #(.WIDTH(32), .AW(32)) dut32 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid & ~sel64), .in_ready(a_in_ready), .in_op(in_op), .in_addr(in_addr),
    .in_wdata(in_wdata[31:0]), .in_alu(in_alu[31:0]), .in_rd(in_rd), .in_rf_we(in_rf_we),
    .mem_req_valid(a_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(a_req_we),
    .mem_req_addr(a_req_addr), .mem_req_wdata(a_req_wdata), .mem_req_wstrb(a_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata[31:0]),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_rd(a_rd), .out_wdata(a_out_wdata),
    .out_rf_we(a_rf_we), .out_misalign(a_mis)
  );

  ysyx22041405_lsu_hs #(.WIDTH(64), .AW(32)) dut64 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid & sel64), .in_ready(b_in_ready), .in_op(in_op), .in_addr(in_addr),
    .in_wdata(in_wdata), .in_alu(in_alu), .in_rd(in_rd), .in_rf_we(in_rf_we),
    .mem_req_valid(b_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(b_req_we),
    .mem_req_addr(b_req_addr), .mem_req_wdata(b_req_wdata), .mem_req_wstrb(b_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_rd(b_rd), .out_wdata(b_out_wdata),
    .out_rf_we(b_rf_we), .out_misalign(b_mis)
  );

  // Observed view of the selected instance
  logic        o_in_ready, o_req_valid, o_req_we, o_out_valid, o_rf_we, o_mis;
  logic [31:0] o_req_addr;
  logic [63:0] o_req_wdata, o_out_wdata;
  logic [7:0]  o_wstrb;
  logic [4:0]  o_rd;

  always_comb begin
    o_in_ready  = sel64 ? b_in_ready  : a_in_ready;
    o_req_valid = sel64 ? b_req_valid : a_req_valid;
    o_req_we    = sel64 ? b_req_we    : a_req_we;
    o_req_addr  = sel64 ? b_req_addr  : a_req_addr;
    o_req_wdata = sel64 ? b_req_wdata : {32'd0, a_req_wdata};
    o_wstrb     = sel64 ? b_wstrb     : {4'd0, a_wstrb};
    o_out_valid = sel64 ? b_out_valid : a_out_valid;
    o_rd        = sel64 ? b_rd        : a_rd;
    o_out_wdata = sel64 ? b_out_wdata : {32'd0, a_out_wdata};
    o_rf_we     = sel64 ? b_rf_we     : a_rf_we;
    o_mis       = sel64 ? b_mis       : a_mis;
  end

  int total = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: plain byte arithmetic on wide integers.
  task automatic model(input int nbw, input logic [4:0] op, input logic [31:0] addr,
                       input logic [63:0] wd, input logic [63:0] alu, input logic [63:0] rdata,
                       input logic rfwe,
                       output logic go_mem, output logic is_ld, output logic mis,
                       output logic [31:0] eaddr, output logic [63:0] ewdata,
                       output logic [7:0] estrb, output logic [63:0] eout, output logic erfwe);
    logic [127:0] wmask, tmp, lim, val;
    int nbytes, off;
    logic mem;
    nbytes = 1 << op[1:0];
    off    = int'(addr % nbw);
    wmask  = (128'd1 << (8 * nbw)) - 128'd1;
    mem    = op[4] | op[3];
    is_ld  = op[4];
    mis    = mem && ((addr % nbytes) != 0);
    go_mem = mem && !mis;
    eaddr  = addr - off;
    ewdata = 64'(((128'(wd) & wmask) << (8 * off)) & wmask);
    estrb  = 8'((((1 << nbytes) - 1) << off) & ((1 << nbw) - 1));
    tmp    = (128'(rdata) & wmask) >> (8 * off);
    lim    = 128'd1 << (8 * nbytes);
    val    = tmp % lim;
    if (!op[2] && val >= lim / 2) val = val - lim;
    if (mis)        begin eout = 64'd0; erfwe = 1'b0; end
    else if (is_ld) begin eout = 64'(val & wmask); erfwe = rfwe; end
    else if (mem)   begin eout = 64'd0; erfwe = 1'b0; end
    else            begin eout = 64'(128'(alu) & wmask); erfwe = rfwe; end
  endtask

  task automatic run_txn(input logic [4:0] op, input logic [31:0] addr, input logic [63:0] wd,
                         input logic [63:0] alu, input logic [63:0] rdata, input logic [4:0] rd,
                         input logic rfwe, input int req_st, input int rsp_d, input int out_st);
    logic go_mem, is_ld, mis, erfwe;
    logic [31:0] eaddr;
    logic [63:0] ewdata, eout;
    logic [7:0]  estrb;
    model(sel64 ? 8 : 4, op, addr, wd, alu, rdata, rfwe,
          go_mem, is_ld, mis, eaddr, ewdata, estrb, eout, erfwe);
    $display("txn w=%0d op=%b addr=%h wd=%h rdata=%h stalls=%0d/%0d/%0d exp_out=%h",
             sel64 ? 64 : 32, op, addr, wd, rdata, req_st, rsp_d, out_st, eout);
    @(negedge clk);
    chk("in_ready_idle", 64'(o_in_ready), 64'd1);
    in_valid = 1'b1; in_op = op; in_addr = addr; in_wdata = wd; in_alu = alu;
    in_rd = rd; in_rf_we = rfwe;
    @(posedge clk); #1;
    // Keep offering garbage; nothing may be accepted until back in IDLE.
    in_op = 5'($urandom); in_addr = $urandom; in_wdata = {$urandom, $urandom};
    in_alu = {$urandom, $urandom}; in_rd = 5'($urandom); in_rf_we = 1'($urandom);
    if (go_mem) begin
      for (int i = 0; i <= req_st; i++) begin
        @(negedge clk);
        chk("req_valid", 64'(o_req_valid), 64'd1);
        chk("req_we", 64'(o_req_we), 64'(!is_ld));
        chk("req_addr", 64'(o_req_addr), 64'(eaddr));
        chk("req_wstrb", 64'(o_wstrb), 64'(estrb));
        if (!is_ld) chk("req_wdata", o_req_wdata, ewdata);
        chk("out_valid_req", 64'(o_out_valid), 64'd0);
        chk("in_ready_req", 64'(o_in_ready), 64'd0);
        mem_req_ready = (i == req_st);
        mem_rsp_valid = (i < req_st) ? 1'($urandom) : 1'b0;
        mem_rsp_rdata = {$urandom, $urandom};
      end
      @(posedge clk); #1;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      if (is_ld) begin
        for (int i = 0; i <= rsp_d; i++) begin
          @(negedge clk);
          chk("req_valid_wait", 64'(o_req_valid), 64'd0);
          chk("out_valid_wait", 64'(o_out_valid), 64'd0);
          chk("in_ready_wait", 64'(o_in_ready), 64'd0);
          mem_rsp_valid = (i == rsp_d);
          mem_rsp_rdata = (i == rsp_d) ? rdata : {$urandom, $urandom};
        end
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = {$urandom, $urandom};
      end
    end
    for (int i = 0; i <= out_st; i++) begin
      @(negedge clk);
      chk("out_valid", 64'(o_out_valid), 64'd1);
      chk("out_rd", 64'(o_rd), 64'(rd));
      chk("out_rf_we", 64'(o_rf_we), 64'(erfwe));
      chk("out_misalign", 64'(o_mis), 64'(mis));
      if (is_ld || mis || !(op[3] | op[4])) chk("out_wdata", o_out_wdata, eout);
      chk("req_valid_resp", 64'(o_req_valid), 64'd0);
      chk("in_ready_resp", 64'(o_in_ready), 64'd0);
      out_ready = (i == out_st);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    @(negedge clk);
    chk("out_valid_after", 64'(o_out_valid), 64'd0);
    chk("in_ready_after", 64'(o_in_ready), 64'd1);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_in_ready"},  64'(o_in_ready),  64'd1);
    chk({tag, "_req_valid"}, 64'(o_req_valid), 64'd0);
    chk({tag, "_out_valid"}, 64'(o_out_valid), 64'd0);
    chk({tag, "_mis"},       64'(o_mis),       64'd0);
    chk({tag, "_rf_we"},     64'(o_rf_we),     64'd0);
    chk({tag, "_rd"},        64'(o_rd),        64'd0);
    chk({tag, "_wdata"},     o_out_wdata,      64'd0);
  endtask

  task automatic rand_txn();
    int kind, nb;
    logic [1:0] sz;
    logic [4:0] op;
    logic [31:0] addr;
    logic rfwe;
    kind = $urandom_range(0, 3);
    sz   = 2'(sel64 ? $urandom_range(0, 3) : $urandom_range(0, 2));
    nb   = 1 << sz;
    addr = $urandom;
    if ($urandom_range(0, 3) != 0) addr = addr & ~(nb - 1);
    case (kind)
      0: op = {2'b10, 1'($urandom), sz};
      1: op = {2'b01, 1'($urandom), sz};
      2: op = {2'b00, 1'($urandom), sz};
      default: op = {2'b11, 1'($urandom), sz};
    endcase
    rfwe = op[4] ? 1'b1 : 1'($urandom);
    run_txn(op, addr, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
            5'($urandom), rfwe, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
  endtask

  initial begin
    rst = 1'b1; sel64 = 1'b0; in_valid = 1'b0; in_op = '0; in_addr = '0;
    in_wdata = '0; in_alu = '0; in_rd = '0; in_rf_we = 1'b0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_state("rst32");
    sel64 = 1'b1; #1;
    check_reset_state("rst64");
    sel64 = 1'b0;

    // Directed, 32-bit
    run_txn(5'b01000, 32'h8000_0003, 64'h0000_00AB, 64'h0, 64'h0, 5'd3, 1'b1, 0, 0, 0);
    run_txn(5'b10001, 32'h8000_0002, 64'h0, 64'h0, 64'h8001_1234, 5'd5, 1'b1, 0, 0, 0);
    run_txn(5'b10101, 32'h8000_0002, 64'h0, 64'h0, 64'h8001_1234, 5'd6, 1'b1, 0, 0, 0);
    run_txn(5'b10010, 32'h8000_0002, 64'h0, 64'h0, 64'h1234_5678, 5'd7, 1'b1, 0, 0, 0);
    run_txn(5'b00000, 32'h0000_0001, 64'h0, 64'hDEAD_BEEF, 64'h0, 5'd9, 1'b1, 0, 0, 0);
    run_txn(5'b10000, 32'h1000_0001, 64'h0, 64'h0, 64'h0000_8000, 5'd10, 1'b1, 5, 3, 2);
    run_txn(5'b01001, 32'h1000_0002, 64'hCAFE, 64'h0, 64'h0, 5'd11, 1'b1, 5, 0, 2);
    run_txn(5'b11010, 32'h2000_0004, 64'h0, 64'h0, 64'h8765_4321, 5'd12, 1'b1, 1, 1, 0);

    // Directed + random, 64-bit
    sel64 = 1'b1;
    run_txn(5'b10010, 32'h8000_0004, 64'h0, 64'h0, 64'h7FFF_FFFF_0000_0000, 5'd13, 1'b1, 0, 0, 0);
    run_txn(5'b10011, 32'h8000_0008, 64'h0, 64'h0, 64'h8123_4567_89AB_CDEF, 5'd14, 1'b1, 0, 0, 0);
    run_txn(5'b01011, 32'h8000_0004, 64'h1122_3344_5566_7788, 64'h0, 64'h0, 5'd15, 1'b1, 0, 0, 0);
    for (int n = 0; n < 25; n++) rand_txn();

    // Random, 32-bit
    sel64 = 1'b0;
    for (int n = 0; n < 40; n++) rand_txn();

    // Reset while waiting for a load response, then a stray response.
    $display("txn w=32 reset-in-WAIT");
    @(negedge clk);
    in_valid = 1'b1; in_op = 5'b10010; in_addr = 32'h3000_0000; in_rd = 5'd17; in_rf_we = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("rw_req_valid", 64'(o_req_valid), 64'd1);
    mem_req_ready = 1'b1;
    @(posedge clk); #1 mem_req_ready = 1'b0;
    @(negedge clk);
    chk("rw_wait_req_valid", 64'(o_req_valid), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_reset_state("rw");
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk); #1 mem_rsp_valid = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("rw_out_valid", 64'(o_out_valid), 64'd0);
      chk("rw_in_ready", 64'(o_in_ready), 64'd1);
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
